// File: rtl/bullet_pool_pkg.sv
// Shared constants and the bullet slot record for the per-player bullet pool.
package bullet_pool_pkg;
  localparam int COORD_W          = 12;
  localparam int HP_WIDTH         = 3;
  localparam int BULLET_SLOTS     = 4;
  localparam int BULLET_STEP_X    = 6;
  localparam int LIMIT_X          = 600;
  localparam int BULLET_SPAWN_OFS = 40;
  localparam int BULLET_COOLDOWN  = 8;
  localparam int HP_MAX           = 5;

  typedef struct packed {
    logic                      valid;
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } bullet_t;
endpackage

// File: rtl/bullet_pool_if.sv
// Controller/renderer-facing bundle of the bullet pool: fire, geometry and slot state.
interface bullet_pool_if import bullet_pool_pkg::*; #(
  parameter int N_SLOTS  = BULLET_SLOTS,
  parameter int COORD_W  = bullet_pool_pkg::COORD_W,
  parameter int HP_WIDTH = bullet_pool_pkg::HP_WIDTH
);
  logic                        i_frame;
  logic                        i_round_start;
  logic                        i_fire;
  logic signed [COORD_W-1:0]   i_shooter_x;
  logic signed [COORD_W-1:0]   i_shooter_y;
  logic signed [COORD_W-1:0]   i_tgt_x_min;
  logic signed [COORD_W-1:0]   i_tgt_x_max;
  logic signed [COORD_W-1:0]   i_tgt_y_min;
  logic signed [COORD_W-1:0]   i_tgt_y_max;
  logic                        i_tgt_shield;
  logic [N_SLOTS-1:0]          o_valid;
  logic [N_SLOTS*COORD_W-1:0]  o_x;
  logic [N_SLOTS*COORD_W-1:0]  o_y;
  logic                        o_fire_ack;
  logic                        o_hit;
  logic [HP_WIDTH-1:0]         o_tgt_hp;
  logic                        o_tgt_dead;

  modport master (
    output i_frame, i_round_start, i_fire, i_shooter_x, i_shooter_y,
           i_tgt_x_min, i_tgt_x_max, i_tgt_y_min, i_tgt_y_max, i_tgt_shield,
    input  o_valid, o_x, o_y, o_fire_ack, o_hit, o_tgt_hp, o_tgt_dead
  );

  modport slave (
    input  i_frame, i_round_start, i_fire, i_shooter_x, i_shooter_y,
           i_tgt_x_min, i_tgt_x_max, i_tgt_y_min, i_tgt_y_max, i_tgt_shield,
    output o_valid, o_x, o_y, o_fire_ack, o_hit, o_tgt_hp, o_tgt_dead
  );
endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet: moves per frame, retires at the arena edge or on a target hit, reloads on spawn.
module bullet_pool_slot import bullet_pool_pkg::*; #(
  parameter int STEP    = BULLET_STEP_X,
  parameter int DIR_POS = 1,
  parameter int LIMIT_X = bullet_pool_pkg::LIMIT_X
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame,
  input  logic                      i_clear,
  input  logic                      i_spawn,
  input  logic signed [COORD_W-1:0] i_spawn_x,
  input  logic signed [COORD_W-1:0] i_spawn_y,
  input  logic signed [COORD_W-1:0] i_tgt_x_min,
  input  logic signed [COORD_W-1:0] i_tgt_x_max,
  input  logic signed [COORD_W-1:0] i_tgt_y_min,
  input  logic signed [COORD_W-1:0] i_tgt_y_max,
  output bullet_t                   o_slot,
  output logic                      o_free,
  output logic                      o_hit
);
  localparam logic signed [COORD_W-1:0] STEP_S = COORD_W'(STEP);
  localparam logic signed [COORD_W-1:0] LIM_S  = COORD_W'(LIMIT_X);

  bullet_t                   slot_p1;
  logic signed [COORD_W-1:0] x_mv;
  logic                      edge_out;
  logic                      in_box;

  // move and bounds are judged on the post-move x but the pre-frame y
  always_comb begin
    x_mv     = (DIR_POS != 0) ? slot_p1.x + STEP_S : slot_p1.x - STEP_S;
    edge_out = (x_mv > LIM_S) || (x_mv < -LIM_S);
    in_box   = (x_mv >= i_tgt_x_min) && (x_mv <= i_tgt_x_max) &&
               (slot_p1.y >= i_tgt_y_min) && (slot_p1.y <= i_tgt_y_max);
  end

  assign o_hit  = slot_p1.valid && !edge_out && in_box;
  assign o_free = !slot_p1.valid;
  assign o_slot = slot_p1;

  // stage p1: slot record updated on the frame tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_p1 <= '0;
    end else if (i_clear) begin
      slot_p1 <= '0;
    end else if (i_frame) begin
      if (slot_p1.valid) begin
        slot_p1.x <= x_mv;
        if (edge_out || in_box) slot_p1.valid <= 1'b0;
      end else if (i_spawn) begin
        slot_p1 <= '{valid: 1'b1, x: i_spawn_x, y: i_spawn_y};
      end
    end
  end
endmodule

// File: rtl/bullet_pool.sv
// Per-player bullet pool: slot allocation, shot cooldown and opponent HP bookkeeping.
module bullet_pool import bullet_pool_pkg::*; #(
  parameter int N_SLOTS   = BULLET_SLOTS,
  parameter int STEP      = BULLET_STEP_X,
  parameter int DIR_POS   = 1,
  parameter int LIMIT_X   = bullet_pool_pkg::LIMIT_X,
  parameter int SPAWN_OFS = BULLET_SPAWN_OFS,
  parameter int COOLDOWN  = BULLET_COOLDOWN,
  parameter int COORD_W   = bullet_pool_pkg::COORD_W,
  parameter int HP_WIDTH  = bullet_pool_pkg::HP_WIDTH,
  parameter int HP_MAX    = bullet_pool_pkg::HP_MAX
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bullet_pool_if.slave  bus
);
  localparam int CD_W = $clog2(COOLDOWN + 2);
  localparam logic signed [COORD_W-1:0] OFS_S = COORD_W'(SPAWN_OFS);

  bullet_t                    slots [N_SLOTS];
  logic [N_SLOTS-1:0]         free;
  logic [N_SLOTS-1:0]         hits;
  logic [N_SLOTS-1:0]         spawn_sel;
  logic                       found;
  logic                       spawn_ok;
  logic signed [COORD_W-1:0]  spawn_x;
  logic [CD_W-1:0]            cd_p1;
  logic                       ack_p1;
  logic                       hit_p1;
  logic [HP_WIDTH-1:0]        hp_p1;
  logic [N_SLOTS-1:0]         valid_v;
  logic [N_SLOTS*COORD_W-1:0] x_v;
  logic [N_SLOTS*COORD_W-1:0] y_v;

  function automatic int popcount(input logic [N_SLOTS-1:0] v);
    int c = 0;
    for (int k = 0; k < N_SLOTS; k++) c += int'(v[k]);
    return c;
  endfunction

  function automatic logic [HP_WIDTH-1:0] sat_sub(input logic [HP_WIDTH-1:0] hp, input int n);
    if (n >= int'(hp)) return '0;
    return hp - HP_WIDTH'(n);
  endfunction

  // lowest-index slot that was free before this frame wins the spawn
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (free[k] && !found) begin
        spawn_sel[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign spawn_ok = bus.i_frame && !bus.i_round_start && bus.i_fire &&
                    (cd_p1 == '0) && found && !bus.o_tgt_dead;
  assign spawn_x  = (DIR_POS != 0) ? bus.i_shooter_x + OFS_S : bus.i_shooter_x - OFS_S;

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    bullet_pool_slot #(.STEP(STEP), .DIR_POS(DIR_POS), .LIMIT_X(LIMIT_X)) u_slot (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_frame     (bus.i_frame),
      .i_clear     (bus.i_round_start),
      .i_spawn     (spawn_ok && spawn_sel[k]),
      .i_spawn_x   (spawn_x),
      .i_spawn_y   (bus.i_shooter_y),
      .i_tgt_x_min (bus.i_tgt_x_min),
      .i_tgt_x_max (bus.i_tgt_x_max),
      .i_tgt_y_min (bus.i_tgt_y_min),
      .i_tgt_y_max (bus.i_tgt_y_max),
      .o_slot      (slots[k]),
      .o_free      (free[k]),
      .o_hit       (hits[k])
    );
  end

  // stage p1: cooldown, pulses and HP registered one cycle after the frame tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cd_p1  <= '0;
      ack_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      hp_p1  <= HP_WIDTH'(HP_MAX);
    end else if (bus.i_round_start) begin
      cd_p1  <= '0;
      ack_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      hp_p1  <= HP_WIDTH'(HP_MAX);
    end else begin
      ack_p1 <= spawn_ok;
      hit_p1 <= bus.i_frame && (|hits);
      if (bus.i_frame) begin
        if (spawn_ok)            cd_p1 <= CD_W'(COOLDOWN);
        else if (cd_p1 != '0)    cd_p1 <= cd_p1 - CD_W'(1);
        if (!bus.i_tgt_shield)   hp_p1 <= sat_sub(hp_p1, popcount(hits));
      end
    end
  end

  always_comb begin
    valid_v = '0;
    x_v     = '0;
    y_v     = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      valid_v[k]                = slots[k].valid;
      x_v[k*COORD_W +: COORD_W] = slots[k].x;
      y_v[k*COORD_W +: COORD_W] = slots[k].y;
    end
  end

  assign bus.o_valid    = valid_v;
  assign bus.o_x        = x_v;
  assign bus.o_y        = y_v;
  assign bus.o_fire_ack = ack_p1;
  assign bus.o_hit      = hit_p1;
  assign bus.o_tgt_hp   = hp_p1;
  assign bus.o_tgt_dead = (hp_p1 == '0);
endmodule

// File: tb/tb_bullet_pool.sv
// Directed self-checking bench for bullet_pool with default parameters.
module tb_bullet_pool;
  import bullet_pool_pkg::*;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bullet_pool_if #(.N_SLOTS(4), .COORD_W(CW), .HP_WIDTH(3)) ifc ();

  bullet_pool dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.slave)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] slot_x(input int k);
    logic signed [CW-1:0] v;
    v = ifc.o_x[k*CW +: CW];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] slot_y(input int k);
    logic signed [CW-1:0] v;
    v = ifc.o_y[k*CW +: CW];
    return 32'(v);
  endfunction

  // called on a falling edge; returns on the falling edge after the tick
  task automatic frame(input logic f);
    ifc.i_fire  = f;
    ifc.i_frame = 1'b1;
    @(negedge clk);
    ifc.i_frame = 1'b0;
    ifc.i_fire  = 1'b0;
  endtask

  task automatic set_box(input int x0, input int x1, input int y0, input int y1);
    ifc.i_tgt_x_min = CW'(x0);
    ifc.i_tgt_x_max = CW'(x1);
    ifc.i_tgt_y_min = CW'(y0);
    ifc.i_tgt_y_max = CW'(y1);
  endtask

  task automatic round;
    ifc.i_round_start = 1'b1;
    @(negedge clk);
    ifc.i_round_start = 1'b0;
  endtask

  // leaves slot0 at x=94 and slot1 at x=40, both at y=100, cooldown 8
  task automatic make_pair;
    set_box(1000, 1100, 1000, 1100);
    repeat (9) frame(1'b0);
    frame(1'b1);
    repeat (8) frame(1'b0);
    frame(1'b1);
    check("pair_valid", ifc.o_valid, 3);
  endtask

  initial begin
    rst_n             = 1'b0;
    ifc.i_frame       = 1'b0;
    ifc.i_round_start = 1'b0;
    ifc.i_fire        = 1'b0;
    ifc.i_shooter_x   = '0;
    ifc.i_shooter_y   = CW'(100);
    ifc.i_tgt_shield  = 1'b0;
    set_box(1000, 1100, 1000, 1100);
    repeat (2) @(negedge clk);
    check("rst_valid", ifc.o_valid, 0);
    check("rst_x0", slot_x(0), 0);
    check("rst_hp", ifc.o_tgt_hp, 5);
    check("rst_dead", ifc.o_tgt_dead, 0);
    check("rst_ack", ifc.o_fire_ack, 0);
    check("rst_hit", ifc.o_hit, 0);
    rst_n = 1'b1;

    // first shot and flight
    frame(1'b1);
    check("t1_ack", ifc.o_fire_ack, 1);
    check("t1_valid", ifc.o_valid, 1);
    check("t1_x0", slot_x(0), 40);
    check("t1_y0", slot_y(0), 100);
    repeat (5) frame(1'b0);
    check("t1_x0_after5", slot_x(0), 70);
    check("t1_ack_low", ifc.o_fire_ack, 0);
    @(negedge clk);
    check("idle_hold_x0", slot_x(0), 70);
    check("idle_hit", ifc.o_hit, 0);

    // sustained fire, full pool, edge retire and reuse
    round;
    for (int f = 1; f <= 96; f++) begin
      frame(1'b1);
      check($sformatf("t2_ack_f%0d", f), ifc.o_fire_ack,
            (f == 1 || f == 10 || f == 19 || f == 28 || f == 96) ? 1 : 0);
      if (f == 37) check("t2_full_f37", ifc.o_valid, 15);
      if (f == 40) check("t2_x3_f40", slot_x(3), 112);
      if (f == 94) check("t3_x0_598", slot_x(0), 598);
      if (f == 94) check("t3_valid_f94", ifc.o_valid, 15);
      if (f == 95) check("t3_retire_f95", ifc.o_valid, 14);
      if (f == 95) check("t2_x1_f95", slot_x(1), 550);
      if (f == 96) check("t2_reuse_valid", ifc.o_valid, 15);
      if (f == 96) check("t2_reuse_x0", slot_x(0), 40);
    end

    // exactly at the limit stays live
    round;
    ifc.i_shooter_x = CW'(554);
    frame(1'b1);
    check("t3b_spawn_x", slot_x(0), 594);
    frame(1'b0);
    check("t3b_x600", slot_x(0), 600);
    check("t3b_live", ifc.o_valid, 1);
    frame(1'b0);
    check("t3b_retire", ifc.o_valid, 0);
    ifc.i_shooter_x = '0;

    // double hits down to zero HP
    round;
    make_pair;
    set_box(0, 200, 50, 150);
    frame(1'b0);
    check("t4_hp3", ifc.o_tgt_hp, 3);
    check("t4_hit", ifc.o_hit, 1);
    check("t4_retired", ifc.o_valid, 0);
    @(negedge clk);
    check("t4_hit_one_cycle", ifc.o_hit, 0);
    make_pair;
    set_box(0, 200, 50, 150);
    frame(1'b0);
    check("t4_hp1", ifc.o_tgt_hp, 1);
    make_pair;
    set_box(0, 200, 50, 150);
    frame(1'b0);
    check("t4_hp0", ifc.o_tgt_hp, 0);
    check("t4_dead", ifc.o_tgt_dead, 1);
    set_box(1000, 1100, 1000, 1100);
    repeat (9) frame(1'b0);
    frame(1'b1);
    check("t4_dead_noack", ifc.o_fire_ack, 0);
    check("t4_dead_nospawn", ifc.o_valid, 0);
    check("t4_dead_hp", ifc.o_tgt_hp, 0);

    // shielded hit
    round;
    make_pair;
    ifc.i_tgt_shield = 1'b1;
    set_box(0, 200, 50, 150);
    frame(1'b0);
    check("t5_retired", ifc.o_valid, 0);
    check("t5_hit", ifc.o_hit, 1);
    check("t5_hp", ifc.o_tgt_hp, 5);
    ifc.i_tgt_shield = 1'b0;

    // round start beats a simultaneous frame/fire
    round;
    make_pair;
    set_box(95, 105, 50, 150);
    frame(1'b0);
    check("t6_single_hp", ifc.o_tgt_hp, 4);
    check("t6_single_valid", ifc.o_valid, 2);
    set_box(1000, 1100, 1000, 1100);
    ifc.i_round_start = 1'b1;
    ifc.i_frame       = 1'b1;
    ifc.i_fire        = 1'b1;
    @(negedge clk);
    ifc.i_round_start = 1'b0;
    ifc.i_frame       = 1'b0;
    ifc.i_fire        = 1'b0;
    check("t6_clr_valid", ifc.o_valid, 0);
    check("t6_clr_hp", ifc.o_tgt_hp, 5);
    check("t6_clr_ack", ifc.o_fire_ack, 0);
    check("t6_clr_x1", slot_x(1), 0);
    frame(1'b1);
    check("t6_cd_cleared_ack", ifc.o_fire_ack, 1);
    frame(1'b0);
    check("t6_x0_46", slot_x(0), 46);

    // asynchronous reset mid-flight
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", ifc.o_valid, 0);
    check("t6_async_x0", slot_x(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_async_hp", ifc.o_tgt_hp, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
